cpu_multicycle: RTL and testbench

Parametrised multi-cycle RV32I integer core, the successor to the single-cycle `cpu`. Each instruction runs through a 4-state FSM (fetch, decode, execute, writeback) with architectural registers between stages. It adds a run/stall input, halt and illegal-instruction detection, a retire strobe and the full OP/OP-IMM ALU set. Instruction ROM and register initial values are port-loaded, and the internal state is exposed for benches.

---
 rtl/cpu_multicycle.sv | 125 ++++++++++++
 tb/tb_cpu_multicycle.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: 4-state multi-cycle RV32I OP/OP-IMM core with stall, halt and illegal detection.
// Optional BEQ/BNE support when CPU_BRANCH_EN is defined.
module cpu_multicycle #(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               run,
    input  logic [IMEM_DEPTH-1:0][31:0]        initial_instructions,
    input  logic [NUM_REGS-1:0][XLEN-1:0]      initial_register_values,
    output logic [XLEN-1:0]                    pc_out_check,
    output logic [31:0]                        instruction_check,
    output logic [2:0]                         state_check,
    output logic [XLEN-1:0]                    alu_result_check,
    output logic                               retire,
    output logic                               halted,
    output logic                               illegal,
    output logic [NUM_REGS-1:0][XLEN-1:0]      register_check
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int SW = $clog2(XLEN);
    localparam int RW = $clog2(NUM_REGS);
    localparam logic [XLEN-1:0] PC_MASK = XLEN'(4 * IMEM_DEPTH - 1);
    localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2,
                           WRITEBACK = 3'd3, HALT = 3'd4, ILLEGAL = 3'd5;

    logic [2:0]                    state_q, state_d;
    logic [XLEN-1:0]               pc_q, a_q, b_q, imm_q, alu_q, alu_d, opb, pc_plus4;
    logic [31:0]                   ir_q;
    logic [NUM_REGS-1:0][XLEN-1:0] regs_q;
    logic [2:0]                    f3;
    logic [6:0]                    f7;
    logic [SW-1:0]                 shamt;
    logic [RW-1:0]                 rd;
    logic                          is_op, is_imm, is_br, legal;

    assign f3       = ir_q[14:12];
    assign f7       = ir_q[31:25];
    assign rd       = ir_q[7 +: RW];
    assign is_op    = ir_q[6:0] == 7'b0110011;
    assign is_imm   = ir_q[6:0] == 7'b0010011;
    assign pc_plus4 = (pc_q + XLEN'(4)) & PC_MASK;
`ifdef CPU_BRANCH_EN
    assign is_br = ir_q[6:0] == 7'b1100011 && f3[2:1] == 2'b00;
`else
    assign is_br = 1'b0;
`endif

    // SUB and SRA/SRAI are the only encodings that allow funct7 = 0100000.
    assign legal = (is_op && (f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
                || (is_imm && (f3 == 3'b001 ? f7 == 7'b0 :
                               f3 == 3'b101 ? (f7 == 7'b0 || f7 == 7'b0100000) : 1'b1))
                || is_br;

    always_comb begin
        state_d = state_q == FETCH     ? DECODE :
                  state_q == DECODE    ? (ir_q == '0 ? HALT : legal ? EXECUTE : ILLEGAL) :
                  state_q == EXECUTE   ? WRITEBACK :
                  state_q == WRITEBACK ? FETCH : state_q;
    end

    always_comb begin
        opb   = is_op ? b_q : imm_q;
        shamt = opb[SW-1:0];
        alu_d = '0;
        case (f3)
            3'b000:  alu_d = (is_op && f7[5]) ? a_q - opb : a_q + opb;
            3'b001:  alu_d = a_q << shamt;
            3'b010:  alu_d = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(opb)};
            3'b011:  alu_d = {{(XLEN-1){1'b0}}, a_q < opb};
            3'b100:  alu_d = a_q ^ opb;
            3'b101:  alu_d = f7[5] ? XLEN'($signed(a_q) >>> shamt) : a_q >> shamt;
            3'b110:  alu_d = a_q | opb;
            default: alu_d = a_q & opb;
        endcase
`ifdef CPU_BRANCH_EN
        // Branches park the resolved next PC in the ALU register for writeback.
        if (is_br)
            alu_d = ((a_q == b_q) ^ f3[0]) ?
                    (pc_q + {{(XLEN-12){ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0}) & PC_MASK :
                    pc_plus4;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            alu_q     <= '0;
            regs_q    <= initial_register_values;
            regs_q[0] <= '0;
        end else if (run) begin
            state_q <= state_d;
            if (state_q == FETCH)
                ir_q <= initial_instructions[pc_q[AW+1:2]];
            if (state_q == DECODE) begin
                a_q   <= regs_q[ir_q[15 +: RW]];
                b_q   <= regs_q[ir_q[20 +: RW]];
                imm_q <= {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
            end
            if (state_q == EXECUTE)
                alu_q <= alu_d;
            if (state_q == WRITEBACK) begin
                pc_q <= is_br ? alu_q : pc_plus4;
                if (!is_br && rd != '0)
                    regs_q[rd] <= alu_q;
            end
        end
    end

    assign pc_out_check      = pc_q;
    assign instruction_check = ir_q;
    assign state_check       = state_q;
    assign alu_result_check  = alu_q;
    assign retire            = run && state_q == WRITEBACK;
    assign halted            = state_q == HALT || state_q == ILLEGAL;
    assign illegal           = state_q == ILLEGAL;
    assign register_check    = regs_q;
endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: directed self-checking bench for cpu_multicycle.
module tb_cpu_multicycle;
    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  run = 1'b1;
    logic [31:0][31:0]     rom;
    logic [31:0][31:0]     init_regs;
    logic [31:0]           pc, ir, alu;
    logic [2:0]            state;
    logic                  retire, halted, illegal;
    logic [31:0][31:0]     regs;
    int                    n_checks = 0;
    int                    n_fail = 0;

    cpu_multicycle #(.XLEN(32), .IMEM_DEPTH(32), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset), .run(run),
        .initial_instructions(rom), .initial_register_values(init_regs),
        .pc_out_check(pc), .instruction_check(ir), .state_check(state),
        .alu_result_check(alu), .retire(retire), .halted(halted), .illegal(illegal),
        .register_check(regs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_seq();
        rom    = '0;
        rom[0] = 32'h005303b3;
        rom[1] = 32'h40848533;
        rom[2] = 32'h00160693;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) init_regs[i] = 32'(3000 + i);

        // reset state and single-instruction latency
        load_seq();
        @(negedge clk);
        reset = 1'b1;
        step(1);
        chk("rst_state", {29'b0, state}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_alu", alu, 32'd0);
        chk("rst_flags", {29'b0, retire, halted, illegal}, 32'd0);
        chk("rst_x0", regs[0], 32'd0);
        chk("rst_x5", regs[5], 32'd3005);
        @(negedge clk);
        reset = 1'b0;
        step(1);
        chk("lat_c1_state", {29'b0, state}, 32'd1);
        chk("lat_c1_ir", ir, 32'h005303b3);
        chk("lat_c1_retire", {31'b0, retire}, 32'd0);
        step(1);
        chk("lat_c2_state", {29'b0, state}, 32'd2);
        chk("lat_c2_retire", {31'b0, retire}, 32'd0);
        step(1);
        chk("lat_c3_state", {29'b0, state}, 32'd3);
        chk("lat_c3_alu", alu, 32'd6011);
        chk("lat_c3_retire", {31'b0, retire}, 32'd1);
        chk("lat_c3_x7_old", regs[7], 32'd3007);
        step(1);
        chk("lat_x7", regs[7], 32'd6011);
        chk("lat_pc", pc, 32'd4);
        chk("lat_c4_retire", {31'b0, retire}, 32'd0);

        // multi-instruction sequence and halt
        do_reset();
        step(8);
        chk("seq_x10", regs[10], 32'd1);
        step(4);
        chk("seq_x13", regs[13], 32'd3013);
        step(2);
        chk("seq_halted", {31'b0, halted}, 32'd1);
        chk("seq_illegal", {31'b0, illegal}, 32'd0);
        chk("seq_state", {29'b0, state}, 32'd4);
        chk("seq_pc", pc, 32'd12);
        step(3);
        chk("seq_halt_hold", {29'b0, state}, 32'd4);
        chk("seq_halt_pc", pc, 32'd12);

        // stall during the first EXECUTE
        do_reset();
        step(2);
        chk("stall_enter", {29'b0, state}, 32'd2);
        run = 1'b0;
        step(5);
        chk("stall_state", {29'b0, state}, 32'd2);
        chk("stall_x7", regs[7], 32'd3007);
        chk("stall_pc", pc, 32'd0);
        @(negedge clk);
        run = 1'b1;
        step(1);
        chk("stall_res_state", {29'b0, state}, 32'd3);
        chk("stall_res_retire", {31'b0, retire}, 32'd1);
        run = 1'b0;
        #1;
        chk("stall_retire_forced", {31'b0, retire}, 32'd0);
        run = 1'b1;
        step(1);
        chk("stall_x7_done", regs[7], 32'd6011);
        chk("stall_pc_done", pc, 32'd4);

        // illegal encoding (JAL)
        rom    = '0;
        rom[0] = 32'h0000006F;
        do_reset();
        step(2);
        chk("ill_state", {29'b0, state}, 32'd5);
        chk("ill_flags", {30'b0, halted, illegal}, 32'd3);
        chk("ill_pc", pc, 32'd0);
        chk("ill_regs_kept", {31'b0, regs[31:1] === init_regs[31:1]}, 32'd1);
        step(2);
        chk("ill_hold", {29'b0, state}, 32'd5);

        // branch opcode: illegal unless the branch option is built in
        rom    = '0;
        rom[0] = 32'h00000063;
        do_reset();
        step(2);
`ifdef CPU_BRANCH_EN
        chk("br_decode", {29'b0, state}, 32'd2);
`else
        chk("br_decode", {29'b0, state}, 32'd5);
`endif

        // x0 write discarded, signed vs unsigned compare
        rom    = '0;
        rom[0] = 32'h00508013;
        rom[1] = 32'hFFF1A113;
        rom[2] = 32'hFFF1B113;
        do_reset();
        step(3);
        chk("x0_alu", alu, 32'd3006);
        step(1);
        chk("x0_stays", regs[0], 32'd0);
        step(4);
        chk("slti", regs[2], 32'd0);
        step(4);
        chk("sltiu", regs[2], 32'd1);

        // shifts, logic ops and compares on negative operands
        rom    = '0;
        rom[0] = 32'hFF800093;
        rom[1] = 32'h4010D113;
        rom[2] = 32'h01C0D193;
        rom[3] = 32'h00409213;
        rom[4] = 32'h0051C293;
        rom[5] = 32'h0042E333;
        rom[6] = 32'h003373B3;
        rom[7] = 32'h0030A433;
        rom[8] = 32'h0030B4B3;
        do_reset();
        step(40);
        chk("alu_addi_neg", regs[1], 32'hFFFFFFF8);
        chk("alu_srai", regs[2], 32'hFFFFFFFC);
        chk("alu_srli", regs[3], 32'h0000000F);
        chk("alu_slli", regs[4], 32'hFFFFFF80);
        chk("alu_xori", regs[5], 32'h0000000A);
        chk("alu_or", regs[6], 32'hFFFFFF8A);
        chk("alu_and", regs[7], 32'h0000000A);
        chk("alu_slt", regs[8], 32'd1);
        chk("alu_sltu", regs[9], 32'd0);
        chk("alu_halt_pc", pc, 32'd36);

        // async reset between edges during EXECUTE of sub
        load_seq();
        do_reset();
        step(6);
        chk("arst_pre_state", {29'b0, state}, 32'd2);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_state", {29'b0, state}, 32'd0);
        chk("arst_pc", pc, 32'd0);
        chk("arst_ir", ir, 32'd0);
        chk("arst_alu", alu, 32'd0);
        chk("arst_x10", regs[10], 32'd3010);
        chk("arst_x7", regs[7], 32'd3007);
        @(negedge clk);
        reset = 1'b0;
        step(4);
        chk("arst_restart_x7", regs[7], 32'd6011);
        chk("arst_restart_pc", pc, 32'd4);
        chk("arst_restart_x10", regs[10], 32'd3010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
